// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap entry/return sequencer.
package trap_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SAFE = 3'd1,
    ST_SAVE      = 3'd2,
    ST_JUMP      = 3'd3,
    ST_MRET      = 3'd4
  } state_e;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef struct packed {
    logic ext;
    logic timer;
  } irq_req_t;

  function automatic logic [31:0] irq_mcause(input logic [3:0] code);
    return {1'b1, 27'b0, code};
  endfunction
endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-side signal bundle of the trap sequencer.
interface trap_sequencer_if;
  logic        irq_ext, irq_timer, mstatus_mie, mie_meie, mie_mtie;
  logic        stall, br_taken, is_mret;
  logic [31:0] pc_kill, mtvec, mepc;
  logic        trap_flush, redirect_en, epc_we, cause_we, mie_clr, mie_set, busy;
  logic [31:0] redirect_pc, epc_wdata, cause_wdata;

  modport slave (
    input  irq_ext, irq_timer, mstatus_mie, mie_meie, mie_mtie,
           stall, br_taken, is_mret, pc_kill, mtvec, mepc,
    output trap_flush, redirect_en, redirect_pc, epc_we, epc_wdata,
           cause_we, cause_wdata, mie_clr, mie_set, busy
  );

  modport master (
    output irq_ext, irq_timer, mstatus_mie, mie_meie, mie_mtie,
           stall, br_taken, is_mret, pc_kill, mtvec, mepc,
    input  trap_flush, redirect_en, redirect_pc, epc_we, epc_wdata,
           cause_we, cause_wdata, mie_clr, mie_set, busy
  );
endinterface

// File: rtl/trap_sequencer_irq_priority_enc.sv
// Fixed-priority interrupt encoder: external beats timer.
module irq_priority_enc
  import trap_pkg::*;
(
  input  irq_req_t   req,
  output logic       valid,
  output logic [3:0] code
);
  always_comb begin
    valid = req.ext | req.timer;
    code  = 4'd0;
    if (req.ext)        code = CAUSE_MEI;
    else if (req.timer) code = CAUSE_MTI;
  end
endmodule

// File: rtl/trap_sequencer.sv
// Interrupt entry (wait for safe point, save, jump) and MRET return sequencer.
module trap_sequencer
  import trap_pkg::*;
(
  input logic             clk,
  input logic             rst,
  trap_sequencer_if.slave bus
);
  state_e      state, nxt;
  logic [31:0] epc;
  logic [3:0]  code;
  irq_req_t    req;
  logic        pending;
  logic [3:0]  enc_code;
  logic [31:0] base, jump_pc;

  assign req.ext   = bus.mstatus_mie & bus.irq_ext   & bus.mie_meie;
  assign req.timer = bus.mstatus_mie & bus.irq_timer & bus.mie_mtie;

  irq_priority_enc u_enc (.req(req), .valid(pending), .code(enc_code));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      epc   <= 32'd0;
      code  <= 4'd0;
    end else begin
      state <= nxt;
      if (state == ST_WAIT_SAFE && nxt == ST_SAVE) begin
        epc  <= bus.pc_kill;
        code <= enc_code;
      end
    end
  end

  // Only 01 selects vectored mode; 1x falls back to direct.
  assign base    = {bus.mtvec[31:2], 2'b00};
  assign jump_pc = (bus.mtvec[1:0] == MTVEC_VECTORED) ? base + {26'd0, code, 2'b00} : base;

  always_comb begin
    nxt             = state;
    bus.trap_flush  = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.epc_we      = 1'b0;
    bus.epc_wdata   = 32'd0;
    bus.cause_we    = 1'b0;
    bus.cause_wdata = 32'd0;
    bus.mie_clr     = 1'b0;
    bus.mie_set     = 1'b0;
    bus.busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (bus.is_mret) nxt = ST_MRET;
        else if (pending) nxt = ST_WAIT_SAFE;
      end
      ST_WAIT_SAFE: begin
        if (!pending) nxt = ST_IDLE;
        else if (!bus.stall && !bus.br_taken) nxt = ST_SAVE;
      end
      ST_SAVE: begin
        nxt             = ST_JUMP;
        bus.trap_flush  = 1'b1;
        bus.epc_we      = 1'b1;
        bus.epc_wdata   = epc;
        bus.cause_we    = 1'b1;
        bus.cause_wdata = irq_mcause(code);
        bus.mie_clr     = 1'b1;
      end
      ST_JUMP: begin
        nxt             = ST_IDLE;
        bus.trap_flush  = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = jump_pc;
      end
      ST_MRET: begin
        nxt             = ST_IDLE;
        bus.trap_flush  = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = bus.mepc;
        bus.mie_set     = 1'b1;
      end
      default: nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus a randomized run against a phase-queue model.
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  trap_sequencer_if bus();
  trap_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic        trap_flush, redirect_en;
    logic [31:0] redirect_pc;
    logic        epc_we;
    logic [31:0] epc_wdata;
    logic        cause_we;
    logic [31:0] cause_wdata;
    logic        mie_clr, mie_set, busy;
  } out_t;

  typedef enum {P_IDLE, P_WAIT, P_SAVE, P_JUMP, P_MRET} ph_e;
  typedef struct {
    ph_e        k;
    logic [31:0] epc;
    logic [3:0]  code;
  } phase_t;

  function automatic out_t obs();
    out_t o;
    o.trap_flush  = bus.trap_flush;  o.redirect_en = bus.redirect_en;
    o.redirect_pc = bus.redirect_pc; o.epc_we      = bus.epc_we;
    o.epc_wdata   = bus.epc_wdata;   o.cause_we    = bus.cause_we;
    o.cause_wdata = bus.cause_wdata; o.mie_clr     = bus.mie_clr;
    o.mie_set     = bus.mie_set;     o.busy        = bus.busy;
    return o;
  endfunction

  // Expected pins for a sequencer phase, using the CSR values currently presented.
  function automatic out_t mk(input ph_e k, input logic [31:0] epc, input logic [3:0] code);
    out_t e = '0;
    logic [31:0] base = {bus.mtvec[31:2], 2'b00};
    case (k)
      P_WAIT: e.busy = 1'b1;
      P_SAVE: begin
        e.busy = 1; e.trap_flush = 1; e.epc_we = 1; e.cause_we = 1; e.mie_clr = 1;
        e.epc_wdata = epc; e.cause_wdata = 32'h8000_0000 | 32'(code);
      end
      P_JUMP: begin
        e.busy = 1; e.trap_flush = 1; e.redirect_en = 1;
        e.redirect_pc = (bus.mtvec[1:0] == 2'b01) ? base + 32'(code) * 4 : base;
      end
      P_MRET: begin
        e.busy = 1; e.trap_flush = 1; e.redirect_en = 1; e.mie_set = 1;
        e.redirect_pc = bus.mepc;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.irq_ext = 0; bus.irq_timer = 0; bus.mstatus_mie = 1; bus.mie_meie = 1; bus.mie_mtie = 1;
    bus.stall = 0; bus.br_taken = 0; bus.is_mret = 0;
    bus.pc_kill = 32'h0; bus.mtvec = 32'h100; bus.mepc = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.irq_timer = 1; bus.is_mret = 1;
    rst = 1; tick(); tick();
    checks++;
    if (obs() !== out_t'(0)) begin errors++; $display("FAIL reset got=%h exp=0", obs()); end
    rst = 0; idle_inputs(); tick();
    checks++;
    if (obs() !== out_t'(0)) begin errors++; $display("FAIL reset_idle got=%h exp=0", obs()); end
  endtask

  task automatic test_direct_timer();
    idle_inputs();
    bus.mtvec = 32'h100; bus.pc_kill = 32'h40; bus.irq_timer = 1;
    tick();
    checks++;
    if (obs() !== mk(P_WAIT, 0, 0)) begin errors++; $display("FAIL dir_wait got=%h exp=%h", obs(), mk(P_WAIT, 0, 0)); end
    tick();
    checks++;
    if (obs() !== mk(P_SAVE, 32'h40, 4'd7) || bus.cause_wdata !== 32'h8000_0007 || bus.epc_wdata !== 32'h40) begin
      errors++; $display("FAIL dir_save got=%h exp=%h", obs(), mk(P_SAVE, 32'h40, 4'd7));
    end
    bus.irq_timer = 0;
    tick();
    checks++;
    if (obs() !== mk(P_JUMP, 0, 4'd7) || bus.redirect_pc !== 32'h100) begin
      errors++; $display("FAIL dir_jump got=%h exp redirect_pc=00000100", obs());
    end
    tick();
    checks++;
    if (obs() !== out_t'(0)) begin errors++; $display("FAIL dir_idle got=%h exp=0", obs()); end
  endtask

  task automatic test_vectored_ext();
    idle_inputs();
    bus.mtvec = 32'h101; bus.pc_kill = 32'h2000; bus.irq_ext = 1; bus.irq_timer = 1;
    tick(); tick();
    checks++;
    if (bus.cause_wdata !== 32'h8000_000B || bus.epc_wdata !== 32'h2000 || !bus.cause_we) begin
      errors++; $display("FAIL vec_save got cause=%h epc=%h exp cause=8000000b epc=00002000", bus.cause_wdata, bus.epc_wdata);
    end
    bus.irq_ext = 0; bus.irq_timer = 0;
    tick();
    checks++;
    if (bus.redirect_pc !== 32'h12C || !bus.redirect_en) begin
      errors++; $display("FAIL vec_jump got=%h exp=0000012c", bus.redirect_pc);
    end
    tick();
  endtask

  task automatic test_stall_hold();
    idle_inputs();
    bus.stall = 1; bus.irq_timer = 1; bus.pc_kill = 32'h88;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== mk(P_WAIT, 0, 0)) begin errors++; $display("FAIL stall_wait%0d got=%h exp=%h", i, obs(), mk(P_WAIT, 0, 0)); end
    end
    bus.stall = 0;
    tick();
    checks++;
    if (obs() !== mk(P_SAVE, 32'h88, 4'd7)) begin errors++; $display("FAIL stall_save got=%h exp=%h", obs(), mk(P_SAVE, 32'h88, 4'd7)); end
    bus.irq_timer = 0;
    tick(); tick();
  endtask

  task automatic test_withdraw();
    idle_inputs();
    bus.br_taken = 1; bus.irq_ext = 1;
    tick();
    bus.irq_ext = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== out_t'(0)) begin errors++; $display("FAIL withdraw%0d got=%h exp=0", i, obs()); end
    end
  endtask

  task automatic test_mret_priority();
    idle_inputs();
    bus.mepc = 32'h44; bus.is_mret = 1; bus.irq_ext = 1; bus.pc_kill = 32'h300;
    tick();
    checks++;
    if (obs() !== mk(P_MRET, 0, 0) || bus.redirect_pc !== 32'h44 || !bus.mie_set) begin
      errors++; $display("FAIL mret got=%h exp=%h", obs(), mk(P_MRET, 0, 0));
    end
    bus.is_mret = 0;
    tick(); tick(); tick();
    checks++;
    if (obs() !== mk(P_SAVE, 32'h300, 4'd11)) begin errors++; $display("FAIL mret_trap got=%h exp=%h", obs(), mk(P_SAVE, 32'h300, 4'd11)); end
    bus.irq_ext = 0;
    tick(); tick();
  endtask

  task automatic test_rst_in_save();
    idle_inputs();
    bus.irq_timer = 1;
    tick(); tick();
    rst = 1; bus.irq_timer = 0;
    tick();
    checks++;
    if (obs() !== out_t'(0)) begin errors++; $display("FAIL rst_save got=%h exp=0", obs()); end
    rst = 0;
    tick();
    checks++;
    if (obs() !== out_t'(0)) begin errors++; $display("FAIL rst_after got=%h exp=0", obs()); end
  endtask

  // Model: the current phase plus a queue of phases already committed to follow it.
  task automatic test_random();
    phase_t cur, nx;
    phase_t fut[$];
    logic q_ext, q_tmr, pend;
    int bad = 0;
    cur = '{P_IDLE, 32'h0, 4'h0};
    rst = 1; idle_inputs(); tick(); rst = 0;
    for (int n = 0; n < 600; n++) begin
      rst             = ($urandom_range(0, 40) == 0);
      bus.irq_ext     = ($urandom_range(0, 3) == 0);
      bus.irq_timer   = ($urandom_range(0, 2) == 0);
      bus.mstatus_mie = ($urandom_range(0, 7) != 0);
      bus.mie_meie    = ($urandom_range(0, 3) != 0);
      bus.mie_mtie    = ($urandom_range(0, 3) != 0);
      bus.stall       = ($urandom_range(0, 2) == 0);
      bus.br_taken    = ($urandom_range(0, 3) == 0);
      bus.is_mret     = ($urandom_range(0, 6) == 0);
      bus.pc_kill     = $urandom;
      bus.mtvec       = $urandom;
      bus.mepc        = $urandom;
      q_ext = bus.mstatus_mie & bus.irq_ext & bus.mie_meie;
      q_tmr = bus.mstatus_mie & bus.irq_timer & bus.mie_mtie;
      pend  = q_ext | q_tmr;
      nx = '{P_IDLE, 32'h0, 4'h0};
      if (rst) fut.delete();
      else if (fut.size() > 0) nx = fut.pop_front();
      else if (cur.k == P_IDLE) begin
        if (bus.is_mret) nx.k = P_MRET;
        else if (pend) nx.k = P_WAIT;
      end else if (cur.k == P_WAIT) begin
        if (!pend) nx.k = P_IDLE;
        else if (!bus.stall && !bus.br_taken) begin
          nx = '{P_SAVE, bus.pc_kill, q_ext ? 4'd11 : 4'd7};
          fut.push_back('{P_JUMP, bus.pc_kill, nx.code});
        end else nx.k = P_WAIT;
      end
      cur = nx;
      tick();
      checks++;
      if (obs() !== mk(cur.k, cur.epc, cur.code)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand[%0d] phase=%s got=%h exp=%h", n, cur.k.name(), obs(), mk(cur.k, cur.epc, cur.code));
      end
    end
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_direct_timer();
    test_vectored_ext();
    test_stall_hold();
    test_withdraw();
    test_mret_priority();
    test_rst_in_save();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
